// File: rtl/game_pkg.sv
// Shared types and constants for the arrow game: direction encoding, slot states,
// LFSR seed/taps and the starting number of lives.
package game_pkg;

  typedef enum logic [1:0] {
    DIR_TOP    = 2'b00,
    DIR_BOTTOM = 2'b01,
    DIR_LEFT   = 2'b10,
    DIR_RIGHT  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_ACTIVE,
    SLOT_RETIRE
  } slot_state_e;

  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Taps 16,14,13,11 as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [1:0]  LIVES_INIT = 2'd3;
  localparam logic [9:0]  SCORE_MAX  = 10'd1023;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, advances every clock; maximal-length so a non-zero seed
// never reaches the all-zero state.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  assign state_d = lfsr_next(state_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/arrow_spawner.sv
// Spawns arrows into a pool of slots once per interval of frames, tracks score,
// lives and game-over, and speeds the game up as the score grows.
module arrow_spawner
  import game_pkg::*;
#(
  parameter int NUM_SLOTS     = 4,
  parameter int BASE_INTERVAL = 60,
  parameter int MIN_INTERVAL  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   game_active,
  input  logic [NUM_SLOTS-1:0]   is_hit,
  input  logic [NUM_SLOTS-1:0]   hit_player,
  output logic [NUM_SLOTS-1:0]   valid_out,
  output logic [2*NUM_SLOTS-1:0] direction_out,
  output logic [2:0]             speed_out,
  output logic [9:0]             score,
  output logic [1:0]             lives,
  output logic                   game_over
);

  logic [15:0]          lfsr_w;
  logic                 lfsr_unused;
  logic                 frame_tick;
  logic [NUM_SLOTS-1:0] slot_idle;
  logic [NUM_SLOTS-1:0] spawn_sel;
  logic                 any_idle;
  logic                 spawn;
  logic [6:0]           level;
  logic [7:0]           interval;
  logic [7:0]           cnt_inc;
  logic                 cnt_due;
  logic [10:0]          blk_cnt;
  logic [10:0]          hit_cnt;

  logic [9:0]           score_q, score_d;
  logic [1:0]           lives_q, lives_d;
  logic                 game_over_q, game_over_d;
  logic [7:0]           frame_cnt_q, frame_cnt_d;
  logic [NUM_SLOTS-1:0] is_hit_q;

  function automatic logic [9:0] sat_add_score(input logic [9:0] s, input logic [10:0] n);
    logic [11:0] sum;
    sum = {2'b00, s} + {1'b0, n};
    return (sum > {2'b00, SCORE_MAX}) ? SCORE_MAX : sum[9:0];
  endfunction

  function automatic logic [1:0] sat_sub_lives(input logic [1:0] l, input logic [10:0] n);
    return (n >= {9'd0, l}) ? 2'd0 : l - n[1:0];
  endfunction

  function automatic logic [7:0] calc_interval(input logic [6:0] lvl);
    int raw;
    raw = BASE_INTERVAL - 4 * int'(lvl);
    if (raw < MIN_INTERVAL) raw = MIN_INTERVAL;
    return 8'(raw);
  endfunction

  lfsr16 u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .state_o(lfsr_w)
  );

  // Only the two low bits pick a direction; the rest just feed the sequence.
  assign lfsr_unused = ^lfsr_w[15:2];

  assign frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign level      = score_q[9:3];
  assign interval   = calc_interval(level);
  assign speed_out  = (level > 7'd7) ? 3'd7 : level[2:0];

  // The counter is compared after counting the current tick, so the Nth tick spawns.
  assign cnt_inc  = (frame_cnt_q == 8'hFF) ? 8'hFF : frame_cnt_q + 8'd1;
  assign cnt_due  = (cnt_inc >= interval);
  assign any_idle = |slot_idle;
  assign spawn    = frame_tick && game_active && !game_over_q && cnt_due && any_idle;

  always_comb begin
    spawn_sel = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_idle[i]) begin
        spawn_sel    = '0;
        spawn_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    blk_cnt = '0;
    hit_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      blk_cnt = blk_cnt + 11'(is_hit[i] & ~is_hit_q[i] & ~hit_player[i]);
      hit_cnt = hit_cnt + 11'(hit_player[i]);
    end
  end

  always_comb begin
    score_d     = score_q;
    lives_d     = lives_q;
    frame_cnt_d = frame_cnt_q;
    game_over_d = game_over_q || (lives_q == 2'd0);
    if (!game_over_q) begin
      score_d = sat_add_score(score_q, blk_cnt);
      lives_d = sat_sub_lives(lives_q, hit_cnt);
    end
    // A due spawn blocked by full slots keeps the count so it fires on the next free tick.
    if (spawn) begin
      frame_cnt_d = '0;
    end else if (frame_tick && !(cnt_due && !any_idle)) begin
      frame_cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q     <= '0;
      lives_q     <= LIVES_INIT;
      game_over_q <= 1'b0;
      frame_cnt_q <= '0;
      is_hit_q    <= '0;
    end else begin
      score_q     <= score_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
      frame_cnt_q <= frame_cnt_d;
      is_hit_q    <= is_hit;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    slot_state_e state_q;
    logic        valid_q;
    dir_e        dir_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= SLOT_IDLE;
        valid_q <= 1'b0;
        dir_q   <= DIR_TOP;
      end else begin
        case (state_q)
          SLOT_IDLE: begin
            if (spawn && spawn_sel[i]) begin
              state_q <= SLOT_ACTIVE;
              valid_q <= 1'b1;
              dir_q   <= dir_e'(lfsr_w[1:0]);
            end
          end
          SLOT_ACTIVE: begin
            if (is_hit[i] || game_over_q) begin
              state_q <= SLOT_RETIRE;
              valid_q <= 1'b0;
            end
          end
          SLOT_RETIRE: begin
            state_q <= SLOT_IDLE;
          end
          default: begin
            state_q <= SLOT_IDLE;
            valid_q <= 1'b0;
          end
        endcase
      end
    end

    assign slot_idle[i]          = (state_q == SLOT_IDLE);
    assign valid_out[i]          = valid_q;
    assign direction_out[2*i +: 2] = dir_q;
  end

  assign score     = score_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;

endmodule
